// File: rtl/banco_registros_multi.sv
// Multi-port register file: NRD combinational reads, W0/W1 writes (W1 wins), optional bypass/zero reg, load busy scoreboard.
// Reads are zero-latency, writes and busy bits commit on the rising edge; no backpressure, every request is accepted.
module banco_registros_multi #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic [NRD*ADDR_W-1:0] readReg,
  output logic [NRD*DATA_W-1:0] readData,
  output logic [NRD-1:0]        readBusy,
  input  logic [ADDR_W-1:0]     writeReg0,
  input  logic [DATA_W-1:0]     writeData0,
  input  logic                  RegWrite0,
  input  logic [ADDR_W-1:0]     writeReg1,
  input  logic [DATA_W-1:0]     writeData1,
  input  logic                  RegWrite1,
  input  logic                  setBusy,
  input  logic [ADDR_W-1:0]     busyReg,
  output logic                  anyBusy
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;
  logic              we0;
  logic              we1;
  logic              set_ok;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;

  // Qualified enables: register 0 is inert under ZERO_REG, and W0 yields to W1 on an address clash.
  always_comb begin
    we1    = RegWrite1 && !((ZERO_REG != 0) && (writeReg1 == '0));
    we0    = RegWrite0 && !((ZERO_REG != 0) && (writeReg0 == '0))
             && !(we1 && (writeReg1 == writeReg0));
    set_ok = setBusy && !((ZERO_REG != 0) && (busyReg == '0));
  end

  // Set is applied after clear so a freshly issued load keeps the register pending.
  always_comb begin
    busy_next = busy;
    if (we1)
      busy_next[writeReg1] = 1'b0;
    if (set_ok)
      busy_next[busyReg] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      busy    <= '0;
      anyBusy <= 1'b0;
    end else begin
      if (we0)
        regs[writeReg0] <= writeData0;
      if (we1)
        regs[writeReg1] <= writeData1;
      busy    <= busy_next;
      anyBusy <= |busy_next;
    end
  end

  // Write-first bypass is purely combinational, so it stays active while reset is held.
  always_comb begin
    readData = '0;
    readBusy = '0;
    ra       = '0;
    rd       = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = readReg[k*ADDR_W +: ADDR_W];
      rd = regs[ra];
      if (BYPASS != 0) begin
        if (we0 && (writeReg0 == ra))
          rd = writeData0;
        if (we1 && (writeReg1 == ra))
          rd = writeData1;
      end
      if ((ZERO_REG != 0) && (ra == '0))
        rd = '0;
      readData[k*DATA_W +: DATA_W] = rd;
      readBusy[k]                  = busy[ra];
    end
  end

endmodule

// File: tb/tb_banco_registros_multi.sv
// Bench for banco_registros_multi: bypass and non-bypass instances driven in lockstep.
module tb_banco_registros_multi;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 2;

  logic              CLK = 1'b0;
  logic              RST_n;
  logic [NRD*AW-1:0] readReg;
  logic [NRD*DW-1:0] readData, readData_nb;
  logic [NRD-1:0]    readBusy, readBusy_nb;
  logic [AW-1:0]     writeReg0, writeReg1, busyReg;
  logic [DW-1:0]     writeData0, writeData1;
  logic              RegWrite0, RegWrite1, setBusy;
  logic              anyBusy, anyBusy_nb;

  logic [DW-1:0] rd0, rd1, rd0_nb;
  assign rd0    = readData[DW-1:0];
  assign rd1    = readData[2*DW-1:DW];
  assign rd0_nb = readData_nb[DW-1:0];

  logic [31:0] exp_q[$];
  logic [31:0] e;
  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  banco_registros_multi #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_REG(1), .BYPASS(1)) dut (
    .CLK(CLK), .RST_n(RST_n), .readReg(readReg), .readData(readData), .readBusy(readBusy),
    .writeReg0(writeReg0), .writeData0(writeData0), .RegWrite0(RegWrite0),
    .writeReg1(writeReg1), .writeData1(writeData1), .RegWrite1(RegWrite1),
    .setBusy(setBusy), .busyReg(busyReg), .anyBusy(anyBusy));

  banco_registros_multi #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .CLK(CLK), .RST_n(RST_n), .readReg(readReg), .readData(readData_nb), .readBusy(readBusy_nb),
    .writeReg0(writeReg0), .writeData0(writeData0), .RegWrite0(RegWrite0),
    .writeReg1(writeReg1), .writeData1(writeData1), .RegWrite1(RegWrite1),
    .setBusy(setBusy), .busyReg(busyReg), .anyBusy(anyBusy_nb));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RegWrite0 = 1'b0;
    RegWrite1 = 1'b0;
    setBusy   = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    readReg = {a1, a0};
    #1;
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    idle();
    set_rd(5'd1, 5'd2);
    tick();
    RST_n = 1'b1;
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (rd0 !== e) begin errors++; $display("FAIL reset_rd0 got=%h exp=%h", rd0, e); end
    e = exp_q.pop_front(); checks++;
    if ({30'b0, readBusy} !== e) begin errors++; $display("FAIL reset_busy got=%b exp=%h", readBusy, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, anyBusy} !== e) begin errors++; $display("FAIL reset_anybusy got=%b exp=%h", anyBusy, e); end
  endtask

  task automatic test_zero_reg();
    writeReg0 = 5'd0; writeData0 = 32'h0000_00A1; RegWrite0 = 1'b1;
    set_rd(5'd0, 5'd0);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (rd0 !== e) begin errors++; $display("FAIL zero_no_bypass got=%h exp=%h", rd0, e); end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    tick();
    idle();
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd0 !== e) begin errors++; $display("FAIL zero_after_write got=%h exp=%h", rd0, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, readBusy[0]} !== e) begin errors++; $display("FAIL zero_busy got=%b exp=%h", readBusy[0], e); end
  endtask

  task automatic test_bypass();
    writeReg0 = 5'd13; writeData0 = 32'h0000_A234; RegWrite0 = 1'b1;
    set_rd(5'd13, 5'd0);
    exp_q.push_back(32'h0000_A234);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (rd0 !== e) begin errors++; $display("FAIL bypass_same_cycle got=%h exp=%h", rd0, e); end
    e = exp_q.pop_front(); checks++;
    if (rd0_nb !== e) begin errors++; $display("FAIL nobypass_old got=%h exp=%h", rd0_nb, e); end
    exp_q.push_back(32'h0000_A234);
    tick();
    idle();
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd0_nb !== e) begin errors++; $display("FAIL nobypass_after_edge got=%h exp=%h", rd0_nb, e); end
  endtask

  task automatic test_priority();
    writeReg0 = 5'd16; writeData0 = 32'h1234; RegWrite0 = 1'b1;
    writeReg1 = 5'd16; writeData1 = 32'h2345; RegWrite1 = 1'b1;
    set_rd(5'd16, 5'd16);
    exp_q.push_back(32'h2345);
    e = exp_q.pop_front(); checks++;
    if (rd0 !== e) begin errors++; $display("FAIL prio_bypass got=%h exp=%h", rd0, e); end
    exp_q.push_back(32'h2345);
    exp_q.push_back(32'h2345);
    tick();
    idle();
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd0 !== e) begin errors++; $display("FAIL prio_stored got=%h exp=%h", rd0, e); end
    e = exp_q.pop_front(); checks++;
    if (rd0_nb !== e) begin errors++; $display("FAIL prio_stored_nb got=%h exp=%h", rd0_nb, e); end

    writeReg0 = 5'd16; writeData0 = 32'h1234; RegWrite0 = 1'b1;
    writeReg1 = 5'd24; writeData1 = 32'h2345; RegWrite1 = 1'b1;
    set_rd(5'd16, 5'd24);
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h2345);
    e = exp_q.pop_front(); checks++;
    if (rd0 !== e) begin errors++; $display("FAIL dual_bypass_p0 got=%h exp=%h", rd0, e); end
    e = exp_q.pop_front(); checks++;
    if (rd1 !== e) begin errors++; $display("FAIL dual_bypass_p1 got=%h exp=%h", rd1, e); end
    exp_q.push_back(32'h1234);
    exp_q.push_back(32'h2345);
    tick();
    idle();
    #1;
    e = exp_q.pop_front(); checks++;
    if (rd0 !== e) begin errors++; $display("FAIL dual_stored_p0 got=%h exp=%h", rd0, e); end
    e = exp_q.pop_front(); checks++;
    if (rd1 !== e) begin errors++; $display("FAIL dual_stored_p1 got=%h exp=%h", rd1, e); end
  endtask

  task automatic test_busy();
    setBusy = 1'b1; busyReg = 5'd5;
    set_rd(5'd5, 5'd5);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if ({31'b0, readBusy[0]} !== e) begin errors++; $display("FAIL busy_no_same_cycle got=%b exp=%h", readBusy[0], e); end
    tick();
    idle();
    #1;
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    e = exp_q.pop_front(); checks++;
    if ({31'b0, readBusy[0]} !== e) begin errors++; $display("FAIL busy_set got=%b exp=%h", readBusy[0], e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, anyBusy} !== e) begin errors++; $display("FAIL anybusy_set got=%b exp=%h", anyBusy, e); end

    writeReg0 = 5'd5; writeData0 = 32'h55; RegWrite0 = 1'b1;
    tick();
    idle();
    #1;
    exp_q.push_back(32'h1);
    e = exp_q.pop_front(); checks++;
    if ({31'b0, readBusy[0]} !== e) begin errors++; $display("FAIL busy_after_w0 got=%b exp=%h", readBusy[0], e); end

    writeReg1 = 5'd5; writeData1 = 32'hCAFE; RegWrite1 = 1'b1;
    #1;
    exp_q.push_back(32'h1);
    e = exp_q.pop_front(); checks++;
    if ({31'b0, readBusy[0]} !== e) begin errors++; $display("FAIL busy_no_clear_bypass got=%b exp=%h", readBusy[0], e); end
    tick();
    idle();
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hCAFE);
    e = exp_q.pop_front(); checks++;
    if ({31'b0, readBusy[0]} !== e) begin errors++; $display("FAIL busy_cleared got=%b exp=%h", readBusy[0], e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, anyBusy} !== e) begin errors++; $display("FAIL anybusy_cleared got=%b exp=%h", anyBusy, e); end
    e = exp_q.pop_front(); checks++;
    if (rd0 !== e) begin errors++; $display("FAIL w1_data got=%h exp=%h", rd0, e); end
  endtask

  task automatic test_set_and_clear();
    setBusy = 1'b1; busyReg = 5'd7;
    writeReg1 = 5'd7; writeData1 = 32'h0000_0777; RegWrite1 = 1'b1;
    set_rd(5'd7, 5'd7);
    tick();
    idle();
    #1;
    exp_q.push_back(32'h0000_0777);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h1);
    e = exp_q.pop_front(); checks++;
    if (rd0 !== e) begin errors++; $display("FAIL setclr_data got=%h exp=%h", rd0, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, readBusy[1]} !== e) begin errors++; $display("FAIL setclr_busy got=%b exp=%h", readBusy[1], e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, anyBusy} !== e) begin errors++; $display("FAIL setclr_anybusy got=%b exp=%h", anyBusy, e); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i < 32; i++) begin
      writeReg0 = AW'(i); writeData0 = 32'(i); RegWrite0 = 1'b1;
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      setBusy = 1'b1;
      busyReg = (i == 0) ? 5'd3 : ((i == 1) ? 5'd9 : 5'd20);
      tick();
    end
    idle();
    set_rd(5'd31, 5'd9);
    exp_q.push_back(32'd31);
    exp_q.push_back(32'd9);
    exp_q.push_back(32'h1);
    e = exp_q.pop_front(); checks++;
    if (rd0 !== e) begin errors++; $display("FAIL fill_r31 got=%h exp=%h", rd0, e); end
    e = exp_q.pop_front(); checks++;
    if (rd1 !== e) begin errors++; $display("FAIL fill_r9 got=%h exp=%h", rd1, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'b0, readBusy[1]} !== e) begin errors++; $display("FAIL fill_busy9 got=%b exp=%h", readBusy[1], e); end

    RST_n = 1'b0;
    writeReg0 = 5'd4; writeData0 = 32'hDEAD; RegWrite0 = 1'b1;
    setBusy = 1'b1; busyReg = 5'd11;
    set_rd(5'd4, 5'd4);
    exp_q.push_back(32'hDEAD);
    exp_q.push_back(32'd4);
    e = exp_q.pop_front(); checks++;
    if (rd0 !== e) begin errors++; $display("FAIL rst_bypass got=%h exp=%h", rd0, e); end
    e = exp_q.pop_front(); checks++;
    if (rd0_nb !== e) begin errors++; $display("FAIL rst_nobypass got=%h exp=%h", rd0_nb, e); end
    tick();
    RST_n = 1'b1;
    idle();
    #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if ({31'b0, anyBusy} !== e) begin errors++; $display("FAIL rst_anybusy got=%b exp=%h", anyBusy, e); end
    for (int a = 0; a < 32; a++) begin
      set_rd(AW'(a), AW'(31 - a));
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); checks++;
      if (rd0 !== e) begin errors++; $display("FAIL rst_clear_p0 a=%0d got=%h exp=%h", a, rd0, e); end
      e = exp_q.pop_front(); checks++;
      if (rd1 !== e) begin errors++; $display("FAIL rst_clear_p1 a=%0d got=%h exp=%h", 31 - a, rd1, e); end
      e = exp_q.pop_front(); checks++;
      if ({30'b0, readBusy} !== e) begin errors++; $display("FAIL rst_busy a=%0d got=%b exp=%h", a, readBusy, e); end
    end
  endtask

  initial begin
    RST_n = 1'b0;
    readReg = '0;
    writeReg0 = '0; writeData0 = '0;
    writeReg1 = '0; writeData1 = '0;
    busyReg = '0;
    idle();
    test_reset();
    test_zero_reg();
    test_bypass();
    test_priority();
    test_busy();
    test_set_and_clear();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
